// File: rtl/mbox_port_arbiter_pkg.sv
// Shared types for the MBOX port arbiter slice.
// FSM states, latched command bundle and width helper.
package kl10_mbox_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic read;
        logic write;
        logic pse;
    } mbox_cmd_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mbox_port_arbiter_if.sv
// Requester-port and MBOX-side signal bundle of the port arbiter.
// master = requesters/MBOX environment, slave = arbiter.
interface mbox_port_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 23,
    parameter int DW   = 36
);
    logic [NREQ-1:0]    reqValid;
    logic [NREQ-1:0]    reqRead;
    logic [NREQ-1:0]    reqWrite;
    logic [NREQ-1:0]    reqPSE;
    logic [NREQ*AW-1:0] reqAddr;
    logic [NREQ*DW-1:0] reqData;
    logic [NREQ-1:0]    reqGrant;
    logic               mboxReq;
    logic               mboxRead;
    logic               mboxWrite;
    logic               mboxPSE;
    logic [AW-1:0]      mboxAddr;
    logic [DW-1:0]      mboxWData;
    logic               mboxAck;
    logic [DW-1:0]      mboxRData;
    logic [NREQ-1:0]    respValid;
    logic [DW-1:0]      respData;
    logic [NREQ-1:0]    nxmErr;
    logic               busy;

    modport master (
        output reqValid, reqRead, reqWrite, reqPSE, reqAddr, reqData,
        output mboxAck, mboxRData,
        input  reqGrant, mboxReq, mboxRead, mboxWrite, mboxPSE,
        input  mboxAddr, mboxWData, respValid, respData, nxmErr, busy
    );

    modport slave (
        input  reqValid, reqRead, reqWrite, reqPSE, reqAddr, reqData,
        input  mboxAck, mboxRData,
        output reqGrant, mboxReq, mboxRead, mboxWrite, mboxPSE,
        output mboxAddr, mboxWData, respValid, respData, nxmErr, busy
    );

endinterface

// File: rtl/mbox_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i,
// wrapping N-1 -> 0; one-hot grant plus binary index.
module rr_arbiter
    import kl10_mbox_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    int p;

    // Scan downwards so the nearest port after the pointer overwrites last.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        p       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            p = (int'(ptr_i) + k) % N;
            if (req_i[IW'(p)]) begin
                grant_o            = '0;
                grant_o[IW'(p)]    = 1'b1;
                idx_o              = IW'(p);
            end
        end
    end

endmodule

// File: rtl/mbox_port_arbiter.sv
// Multi-port front end to the MBOX: round-robin grant, one outstanding
// cycle, response/NXM routed back to the owning port.
module mbox_port_arbiter
    import kl10_mbox_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = 23,
    parameter int DW      = 36,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                resetN,
    mbox_port_arbiter_if.slave  bus
);

    localparam int IW = clog2(NREQ);
    localparam int CW = clog2(TIMEOUT);

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_q;
    logic [IW-1:0]   owner_q;
    logic [CW-1:0]   cnt_q;
    mbox_cmd_t       cmd_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [NREQ-1:0] resp_q;
    logic [DW-1:0]   rdata_q;
    logic [NREQ-1:0] nxm_q;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            gnt_en;
    logic            legal;
    logic            tmo_hit;
    mbox_cmd_t       cmd_in;
    logic [AW-1:0]   addr_a [NREQ];
    logic [DW-1:0]   data_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g] = bus.reqAddr[g*AW +: AW];
        assign data_a[g] = bus.reqData[g*DW +: DW];
    end

    rr_arbiter #(.N(NREQ)) u_rr (
        .req_i   (bus.reqValid),
        .ptr_i   (rr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    assign cmd_in  = '{read:  bus.reqRead[arb_idx],
                       write: bus.reqWrite[arb_idx],
                       pse:   bus.reqPSE[arb_idx]};
    assign legal   = cmd_in.read | cmd_in.write;
    assign gnt_en  = resetN && (state_q == IDLE) && (|bus.reqValid);
    assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_en && legal) state_d = BUSY;
            BUSY:    if (bus.mboxAck || tmo_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.reqGrant = gnt_en ? arb_grant : '0;
        bus.mboxReq  = (state_q == BUSY);
        bus.busy     = (state_q == BUSY);
    end

    assign bus.mboxRead  = cmd_q.read;
    assign bus.mboxWrite = cmd_q.write;
    assign bus.mboxPSE   = cmd_q.pse;
    assign bus.mboxAddr  = addr_q;
    assign bus.mboxWData = wdata_q;
    assign bus.respValid = resp_q;
    assign bus.respData  = rdata_q;
    assign bus.nxmErr    = nxm_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rr_q    <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            rdata_q <= '0;
            nxm_q   <= '0;
        end else begin
            resp_q <= '0;
            nxm_q  <= '0;
            cnt_q  <= (state_q == BUSY && state_d == BUSY) ? cnt_q + 1'b1 : '0;
            if (gnt_en) begin
                cmd_q   <= cmd_in;
                addr_q  <= addr_a[arb_idx];
                wdata_q <= data_a[arb_idx];
                owner_q <= arb_idx;
                rr_q    <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                if (!legal) nxm_q <= arb_grant;
            end
            // Ack on the last timeout cycle still completes normally.
            if (state_q == BUSY) begin
                if (bus.mboxAck) begin
                    resp_q  <= NREQ'(1) << owner_q;
                    rdata_q <= cmd_q.read ? bus.mboxRData : '0;
                end else if (tmo_hit) begin
                    nxm_q <= NREQ'(1) << owner_q;
                end
            end
        end
    end

endmodule
